// File: rtl/button_debounce_reader.sv
// Pushbutton reader: two-flop synchroniser, debounce FSM, registered press/release/long-press
// strobes and a wrapping 8-bit press counter. All outputs are flop-driven.
module button_debounce_reader #(
   parameter int DEBOUNCE_CYCLES   = 200000,
   parameter int LONG_PRESS_CYCLES = 20000000,
   parameter bit ACTIVE_LOW        = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_press_pulse,
   output logic [7:0] press_count
);

   localparam logic [26:0] DB_LAST  = 27'(DEBOUNCE_CYCLES - 1);
   localparam logic [26:0] LP_LAST  = 27'(LONG_PRESS_CYCLES - 1);
   localparam logic [26:0] HOLD_MAX = '1;

   typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;

   state_t      state, state_nx;
   logic [1:0]  sync_q;
   logic        raw_s;
   logic [26:0] cnt, cnt_nx;
   logic [26:0] hold_cnt, hold_nx;
   logic        long_done, long_nx;
   logic        level_nx, press_nx, rel_nx, lp_nx;
   logic [7:0]  count_nx;

   // Synchroniser idles at the released pad level so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= {2{ACTIVE_LOW}};
      else        sync_q <= {sync_q[0], btn_in};
   end

   assign raw_s = sync_q[1] ^ ACTIVE_LOW;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= RELEASED;
         cnt              <= '0;
         hold_cnt         <= '0;
         long_done        <= 1'b0;
         btn_level        <= 1'b0;
         press_pulse      <= 1'b0;
         release_pulse    <= 1'b0;
         long_press_pulse <= 1'b0;
         press_count      <= '0;
      end else begin
         state            <= state_nx;
         cnt              <= cnt_nx;
         hold_cnt         <= hold_nx;
         long_done        <= long_nx;
         btn_level        <= level_nx;
         press_pulse      <= press_nx;
         release_pulse    <= rel_nx;
         long_press_pulse <= lp_nx;
         press_count      <= count_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hold_nx  = hold_cnt;
      long_nx  = long_done;
      level_nx = btn_level;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      lp_nx    = 1'b0;
      count_nx = press_count;

      // Hold timing keeps running through release bounces and on the releasing edge itself.
      if (state == PRESSED || state == RELEASE_PEND) begin
         if (hold_cnt != HOLD_MAX) hold_nx = hold_cnt + 27'd1;
         if (hold_cnt == LP_LAST && !long_done) begin
            lp_nx   = 1'b1;
            long_nx = 1'b1;
         end
      end

      case (state)
         RELEASED: begin
            if (raw_s) begin
               state_nx = PRESS_PEND;
               cnt_nx   = '0;
            end
         end
         PRESS_PEND: begin
            if (!raw_s) begin
               state_nx = RELEASED;
            end else if (cnt == DB_LAST) begin
               state_nx = PRESSED;
               level_nx = 1'b1;
               press_nx = 1'b1;
               count_nx = press_count + 8'd1;
               hold_nx  = '0;
               long_nx  = 1'b0;
            end else begin
               cnt_nx = cnt + 27'd1;
            end
         end
         PRESSED: begin
            if (!raw_s) begin
               state_nx = RELEASE_PEND;
               cnt_nx   = '0;
            end
         end
         RELEASE_PEND: begin
            if (raw_s) begin
               state_nx = PRESSED;
            end else if (cnt == DB_LAST) begin
               state_nx = RELEASED;
               level_nx = 1'b0;
               rel_nx   = 1'b1;
            end else begin
               cnt_nx = cnt + 27'd1;
            end
         end
         default: state_nx = RELEASED;
      endcase
   end

endmodule

// File: tb/tb_button_debounce_reader.sv
// Bench for button_debounce_reader: directed scenarios plus random bounce traffic, checked
// every cycle against a run-length model of the debounced button.
module tb_button_debounce_reader;

   localparam int D = 4;
   localparam int L = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_in;
   logic       btn_level, press_pulse, release_pulse, long_press_pulse;
   logic [7:0] press_count;

   logic pressed = 1'b0;   // logical button state; pad is active-low
   assign btn_in = ~pressed;

   int checks = 0;
   int failures = 0;
   int n_press = 0, n_rel = 0, n_long = 0;
   logic [7:0] prev_cnt = 8'd0;
   bit wrap_seen = 1'b0;

   button_debounce_reader #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_press_pulse(long_press_pulse), .press_count(press_count)
   );

   always #5 clk = ~clk;

   // Reference: raw_s is the pressed state two edges late; the level flips once raw_s has
   // disagreed with it for D+1 consecutive edges; long press fires L edges after a press.
   bit        m_q1, m_q2, m_level, m_pp, m_rp, m_lp, m_done;
   int        m_run, m_since;
   logic [7:0] m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q1 <= 0; m_q2 <= 0; m_level <= 0; m_pp <= 0; m_rp <= 0; m_lp <= 0;
         m_done <= 0; m_run <= 0; m_since <= 0; m_cnt <= 0;
      end else begin
         m_q1 <= pressed;
         m_q2 <= m_q1;
         m_pp <= 0; m_rp <= 0; m_lp <= 0;
         if (m_q2 != m_level) begin
            if (m_run == D) begin
               m_level <= m_q2;
               m_run   <= 0;
               if (m_q2) begin
                  m_pp <= 1; m_cnt <= m_cnt + 8'd1; m_since <= 0; m_done <= 0;
               end else begin
                  m_rp <= 1;
               end
            end else begin
               m_run <= m_run + 1;
            end
         end else begin
            m_run <= 0;
         end
         if (m_level) begin
            if (m_since == L - 1 && !m_done) begin
               m_lp <= 1; m_done <= 1;
            end
            m_since <= m_since + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic compare();
      chk("btn_level", 32'(btn_level), 32'(m_level));
      chk("press_pulse", 32'(press_pulse), 32'(m_pp));
      chk("release_pulse", 32'(release_pulse), 32'(m_rp));
      chk("long_press_pulse", 32'(long_press_pulse), 32'(m_lp));
      chk("press_count", 32'(press_count), 32'(m_cnt));
      if (press_pulse === 1'b1) n_press++;
      if (release_pulse === 1'b1) n_rel++;
      if (long_press_pulse === 1'b1) n_long++;
      if (prev_cnt == 8'd255 && press_count == 8'd0) wrap_seen = 1'b1;
      prev_cnt = press_count;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         compare();
      end
   endtask

   // Steps until the selected strobe appears (0 press, 1 release, 2 long) or maxc runs out.
   task automatic wait_for(input int which, input int maxc, output int n);
      logic s;
      n = 0;
      do begin
         step(1);
         n++;
         s = (which == 0) ? press_pulse : (which == 1) ? release_pulse : long_press_pulse;
      end while (s !== 1'b1 && n < maxc);
   endtask

   task automatic reset_now();
      rst_n = 1'b0;
      #1;
      chk("rst_level", 32'(btn_level), 0);
      chk("rst_pulses", 32'({press_pulse, release_pulse, long_press_pulse}), 0);
      chk("rst_count", 32'(press_count), 0);
      @(negedge clk);
      step(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int n, k, base;
      logic [7:0] c0;

      // Reset with button held, then fresh press after full latency
      pressed = 1'b1;
      @(negedge clk);
      reset_now();
      wait_for(0, 20, n);
      chk("reset_press_edge", n, 7);
      chk("reset_press_count", 32'(press_count), 1);

      // Clean release 10 cycles after the press change
      step(3);
      pressed = 1'b0;
      wait_for(1, 20, n);
      chk("release_edge", n, 7);
      chk("release_level", 32'(btn_level), 0);
      chk("no_long_short_press", n_long, 0);

      // Bounce rejection, then settle pressed
      step(10);
      for (int i = 0; i < 10; i++) begin
         pressed = (i % 2 == 0);
         step(2);
         chk("bounce_level", 32'(btn_level), 0);
      end
      pressed = 1'b1;
      wait_for(0, 20, n);
      chk("bounce_press_edge", n, 7);

      // Long press with a 2-cycle release bounce 8 cycles after the press
      base = n_long;
      step(8);
      pressed = 1'b0;
      step(2);
      pressed = 1'b1;
      wait_for(2, 30, n);
      k = 10 + n;
      chk("long_latency", k, L);
      step(20);
      chk("long_once", n_long - base, 1);
      chk("long_level_held", 32'(btn_level), 1);
      pressed = 1'b0;
      wait_for(1, 20, n);
      step(5);

      // 256 clean presses wrap the counter back to its start value
      c0 = press_count;
      base = n_press;
      k = n_rel;
      wrap_seen = 1'b0;
      for (int i = 0; i < 256; i++) begin
         pressed = 1'b1;
         step(8);
         pressed = 1'b0;
         step(8);
      end
      chk("wrap_presses", n_press - base, 256);
      chk("wrap_releases", n_rel - k, 256);
      chk("wrap_count", 32'(press_count), 32'(c0));
      chk("wrap_255_to_0", 32'(wrap_seen), 1);

      // Reset during PRESS_PEND, held through reset release
      pressed = 1'b1;
      step(4);
      reset_now();
      wait_for(0, 20, n);
      chk("pend_reset_press_edge", n, 7);

      // Reset at hold cycle 10: no stale long press afterwards
      step(10);
      base = n_long;
      reset_now();
      wait_for(0, 20, n);
      chk("hold_reset_press_edge", n, 7);
      chk("hold_reset_count", 32'(press_count), 1);
      chk("hold_reset_no_long", n_long - base, 0);
      step(20);
      pressed = 1'b0;
      step(10);

      // Random bounce traffic against the model
      for (int i = 0; i < 60; i++) begin
         pressed = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) step(int'($urandom_range(15, 25)));
         else step(int'($urandom_range(1, 8)));
      end
      pressed = 1'b0;
      step(12);
      chk("final_level", 32'(btn_level), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
